dec_scan_seq: RTL and testbench
===============================

# dec_scan_seq

Upstream sequencer for the 4-to-16 decoder (`dec4to16two`). It drives the decoder's `en` and `w[3:0]` inputs, stepping through the channels selected by a 16-bit mask. Each selected channel is held for a programmable number of cycles, in single-pass or continuous mode, with a start/stop/done handshake to the controlling logic. The block owns the decoder's select and enable timing so that downstream logic sees exactly one decoder output active, for a defined duration.

## Interface
Parameters:
- `DWELL`, default 4: cycles each selected channel holds `en`=1; legal range 1..256.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  starts a scan; sampled only in IDLE.
- `stop`  in  1  aborts a scan; sampled only while `busy`=1.
- `cont`  in  1  continuous mode; latched with `start`.
- `mask`  in  16  channel select mask (bit i = channel i); latched with `start`.
- `en`  out  1  decoder enable.
- `w`  out  4  decoder channel select.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse at scan end or abort.

## Operation
- States: IDLE, DWELL, DONE (plus GAP when `DEC_SCAN_GAP_EN` is defined).
- Reset: state IDLE; `en`=0, `w`=0, `busy`=0, `done`=0; dwell counter = 0; latched mask and mode = 0.
- IDLE with `start`=1:
  - Latch `mask` → `m`, `cont` → `c`.
  - If `mask`==0: go to DONE. `en` never rises.
  - Otherwise: go to DWELL with `w` = lowest set bit of `mask`, `en`=1, `busy`=1, counter=0.
- DWELL, each cycle:
  - Counter increments.
  - When counter==DWELL-1 (last cycle), the next channel is the lowest set bit of `m` strictly above `w`.
  - If no such bit: with `c`=1, wrap to the lowest set bit of `m`; with `c`=0, go to DONE.
  - Otherwise: load the next channel and reset the counter.
  - With a single set bit and `c`=1, the channel stays put and the counter restarts.
- DONE: `en`=0, `busy`=0, `done`=1 for exactly one cycle, then IDLE. `w` holds its last value.
- `stop`=1 in DWELL (or GAP) → DONE next cycle. `stop` has priority over advance and wrap.
- `start` while busy is ignored. `stop` in IDLE is ignored. `mask`/`cont` changes mid-scan are ignored.
- Invariant: `en`=1 implies bit `w` of `m` is 1.
- Async `rst` mid-scan forces the reset values immediately. No `done` pulse is produced.

## Timing
- `start` sampled at edge T → `en`=1, `busy`=1 from T+1.
- Each channel: `en`=1 for exactly DWELL consecutive cycles. `w` changes only on a channel boundary.
- Single pass over N set bits, no gap: `en` high for N·DWELL cycles. `done` high in cycle T+1+N·DWELL.
- `stop` sampled at edge S → `en`=0, `done`=1 at S+1; IDLE at S+2.
- `mask`==0: `done`=1 at T+1, `busy` stays 0.
- A new `start` is accepted in the cycle after `done`, i.e. the first IDLE cycle.

## Configuration
- Macro: `DEC_SCAN_GAP_EN`.
- Defined: one GAP cycle is inserted between consecutive channels, including on wrap.
  - During GAP: `en`=0, `w` already equals the next channel, `busy`=1.
  - No gap is inserted before DONE.
  - Single-pass time becomes N·DWELL + (N-1) cycles.
  - With a single set bit and `c`=1, a gap still occurs every DWELL cycles.
- Undefined: no GAP state exists. Channels switch back-to-back with `en` continuously high.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `en`=0, `w`=0, `busy`=0, `done`=0 immediately. Outputs stay quiet with `start`=0.
- Single pass: DWELL=2, `mask`=16'h8421, `cont`=0, `start` pulse → `w` = 0,0,5,5,10,10,15,15 with `en`=1. Next cycle `en`=0, `done`=1 for one cycle, `busy`=0.
- Continuous wrap: DWELL=1, `mask`=16'h0003, `cont`=1 → `w` = 0,1,0,1,… with `en` continuously 1. `stop` pulse → `done`=1 next cycle, then idle.
- Empty mask / ignored inputs: `mask`=0 with `start` → `done` one cycle later, `en` never 1. A second `start` while busy does not restart the scan. A `mask` change mid-scan has no effect.
- Gap build: with `DEC_SCAN_GAP_EN`, DWELL=2, `mask`=16'h0006 → `en` = 1,1,0,1,1 with `w` = 1,1,2,2,2, then `done`.
- Reset mid-scan: `rst` during channel 5 → `en`=0, no `done`. After release, a new `start` begins at the lowest set bit.

Source files
------------

// File: rtl/dec_scan_seq.sv
// Mask-driven channel scanner feeding the 4-to-16 decoder's en/w inputs.
// Optional macro DEC_SCAN_GAP_EN inserts one en=0 cycle between channels.
module dec_scan_seq #(
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        cont,
  input  logic [15:0] mask,
  output logic        en,
  output logic [3:0]  w,
  output logic        busy,
  output logic        done
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DWELL = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
`ifdef DEC_SCAN_GAP_EN
  localparam logic [1:0] S_GAP   = 2'd3;
`endif

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    w_q, w_d;
  logic [15:0]   m_q, m_d;
  logic          c_q, c_d;

  logic [3:0]    first_in, first_m, nxt_up;
  logic          has_up;

  // Descending loop so the lowest qualifying bit is the last one written.
  always_comb begin
    first_in = 4'd0;
    first_m  = 4'd0;
    nxt_up   = 4'd0;
    has_up   = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) first_in = 4'(i);
      if (m_q[i])  first_m  = 4'(i);
      if (m_q[i] && (4'(i) > w_q)) begin
        has_up = 1'b1;
        nxt_up = 4'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    m_d     = m_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d = mask;
          c_d = cont;
          if (mask == 16'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DWELL;
            w_d     = first_in;
            cnt_d   = '0;
          end
        end
      end
      S_DWELL: begin
        if (stop) begin
          state_d = S_DONE;
        end else if (cnt_q == LAST) begin
          if (has_up || c_q) begin
            // Single-bit continuous scans reload the same channel here.
            w_d   = has_up ? nxt_up : first_m;
            cnt_d = '0;
`ifdef DEC_SCAN_GAP_EN
            state_d = S_GAP;
`endif
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef DEC_SCAN_GAP_EN
      S_GAP: begin
        cnt_d   = '0;
        state_d = stop ? S_DONE : S_DWELL;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      w_q     <= 4'd0;
      m_q     <= 16'd0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      m_q     <= m_d;
      c_q     <= c_d;
    end
  end

  assign en   = (state_q == S_DWELL);
`ifdef DEC_SCAN_GAP_EN
  assign busy = (state_q == S_DWELL) || (state_q == S_GAP);
`else
  assign busy = (state_q == S_DWELL);
`endif
  assign done = (state_q == S_DONE);
  assign w    = w_q;

endmodule

// File: tb/tb_dec_scan_seq.sv
// Bench for dec_scan_seq: DWELL=1 and DWELL=2 instances share stimulus and are
// compared every cycle against a channel-list model of the scan.
module tb_dec_scan_seq;
  logic        clk = 1'b0;
  logic        rst, start, stop, cont;
  logic [15:0] mask;
  logic        en1, busy1, done1, en2, busy2, done2;
  logic [3:0]  w1, w2;

  always #5 clk = ~clk;

  dec_scan_seq #(.DWELL(1)) u_d1 (.clk(clk), .rst(rst), .start(start), .stop(stop),
    .cont(cont), .mask(mask), .en(en1), .w(w1), .busy(busy1), .done(done1));
  dec_scan_seq #(.DWELL(2)) u_d2 (.clk(clk), .rst(rst), .start(start), .stop(stop),
    .cont(cont), .mask(mask), .en(en2), .w(w2), .busy(busy2), .done(done2));

  logic [6:0] obs [2];
  assign obs[0] = {en1, w1, busy1, done1};
  assign obs[1] = {en2, w2, busy2, done2};

`ifdef DEC_SCAN_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Model: the scan is a list of selected channels walked in order, each
  // for DWELL cycles, optionally separated by one idle gap cycle.
  int chans [2][16];
  int nch [2], pos [2], left [2], lastw [2];
  bit act [2], gap [2], dn [2], cm [2];

  function automatic int dw(input int k);
    return k + 1;
  endfunction

  function automatic logic [6:0] exp_vec(input int k);
    return {act[k] && !gap[k], 4'(lastw[k]), act[k], dn[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      act[k] = 0; gap[k] = 0; dn[k] = 0; lastw[k] = 0; nch[k] = 0; pos[k] = 0;
      left[k] = 0; cm[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        act[k] = 0; gap[k] = 0; dn[k] = 0; lastw[k] = 0;
      end else if (dn[k]) begin
        dn[k] = 0;
      end else if (!act[k]) begin
        if (start) begin
          nch[k] = 0;
          for (int i = 0; i < 16; i++)
            if (mask[i]) begin chans[k][nch[k]] = i; nch[k]++; end
          cm[k] = cont;
          if (nch[k] == 0) dn[k] = 1;
          else begin
            act[k] = 1; pos[k] = 0; left[k] = dw(k); gap[k] = 0; lastw[k] = chans[k][0];
          end
        end
      end else if (stop) begin
        act[k] = 0; gap[k] = 0; dn[k] = 1;
      end else if (gap[k]) begin
        gap[k] = 0; left[k] = dw(k);
      end else begin
        left[k]--;
        if (left[k] == 0) begin
          if (pos[k] + 1 < nch[k]) pos[k]++;
          else if (cm[k]) pos[k] = 0;
          else begin act[k] = 0; dn[k] = 1; end
          if (act[k]) begin
            lastw[k] = chans[k][pos[k]];
            if (GAP) gap[k] = 1; else left[k] = dw(k);
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; start = 0; stop = 0; cont = 0; mask = 16'd0;
    model_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 7'd0) begin
        errors++;
        $display("FAIL reset_init inst=%0d got=%b exp=%b", k, obs[k], 7'd0);
      end
    end
    step(); step();
    rst = 0;
    for (int n = 0; n < 4; n++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL reset_quiet inst=%0d t=%0t got=%b exp=%b", k, $time, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_single_pass();
    mask = 16'h8421; cont = 0; start = 1;
    for (int n = 0; n < 14; n++) begin
      step();
      start = 0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL single_pass inst=%0d t=%0t got=%b exp=%b", k, $time, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_cont_wrap();
    mask = 16'h0003; cont = 1; start = 1;
    for (int n = 0; n < 16; n++) begin
      step();
      start = 0;
      stop = (n == 10);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL cont_wrap inst=%0d t=%0t got=%b exp=%b", k, $time, obs[k], exp_vec(k));
        end
      end
    end
    stop = 0;
  endtask

  task automatic test_ignored();
    mask = 16'h0000; cont = 0; start = 1;
    for (int n = 0; n < 16; n++) begin
      step();
      stop = (n == 1);
      start = (n == 2) || (n >= 4 && n <= 6);
      mask = (n == 2) ? 16'h0030 : 16'hffff;
      cont = (n >= 4);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL ignored inst=%0d t=%0t got=%b exp=%b", k, $time, obs[k], exp_vec(k));
        end
      end
    end
    start = 0; stop = 0; cont = 0;
    step(); step(); step();
  endtask

  task automatic test_gap();
    mask = 16'h0006; cont = 0; start = 1;
    for (int n = 0; n < 10; n++) begin
      step();
      start = 0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL gap inst=%0d t=%0t got=%b exp=%b", k, $time, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 0;
    mask = 16'h0024; cont = 1; start = 1;
    for (int n = 0; n < 20 && !hit; n++) begin
      step();
      start = 0;
      hit = act[1] && !gap[1] && lastw[1] == 5;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_reach got=%0d exp=%0d", lastw[1], 5);
    end
    #2 rst = 1;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 7'd0) begin
        errors++;
        $display("FAIL reset_mid_async inst=%0d got=%b exp=%b", k, obs[k], 7'd0);
      end
    end
    @(negedge clk);
    step();
    rst = 0;
    for (int n = 0; n < 8; n++) begin
      step();
      start = (n == 2);
      mask = 16'h0024; cont = 0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL reset_mid_after inst=%0d t=%0t got=%b exp=%b", k, $time, obs[k], exp_vec(k));
        end
      end
    end
    start = 0;
  endtask

  task automatic test_random();
    logic [15:0] r;
    for (int n = 0; n < 2000; n++) begin
      start = ($urandom % 4) == 0;
      stop  = ($urandom % 16) == 0;
      cont  = ($urandom % 3) == 0;
      r = 16'($urandom);
      case ($urandom % 4)
        0: mask = 16'd0;
        1: mask = 16'd1 << ($urandom % 16);
        2: mask = r & 16'($urandom) & 16'($urandom);
        default: mask = r;
      endcase
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL random inst=%0d t=%0t got=%b exp=%b", k, $time, obs[k], exp_vec(k));
        end
      end
    end
    start = 0; stop = 0;
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_cont_wrap();
    test_ignored();
    test_gap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
